// File: rtl/iob_wb_pkg.sv
// +----------------------------------------------------------------------+
// | iob_wb_pkg: shared types and helpers for the IOb-to-Wishbone bridge  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package iob_wb_pkg;

    localparam int BYTE_OFF_W_MAX = 3;  // enough for a 64-bit data bus
    localparam int SEL_MAX_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Contiguous read mask of read_bytes lanes, aligned down to a read_bytes boundary.
    function automatic logic [SEL_MAX_W-1:0] rd_sel_mask(
        input logic [BYTE_OFF_W_MAX-1:0] off,
        input int unsigned               read_bytes
    );
        int unsigned base;
        int unsigned mask;
        base = (int'(off) / read_bytes) * read_bytes;
        mask = (32'd1 << read_bytes) - 32'd1;
        return SEL_MAX_W'(mask << base);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_wb_timeout_cnt.sv
// +----------------------------------------------------------------------+
// | iob_wb_timeout_cnt: saturating wait counter with terminal count      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module iob_wb_timeout_cnt #(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TIMEOUT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {TIMEOUT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // tc is raised in the last allowed wait cycle so the abort lands on the TIMEOUT_CYCLES-th edge.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_tc_off
            assign tc_o = 1'b0;
        end else begin : g_tc_on
            assign tc_o = en_i && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/iob_iob2wb_bridge.sv
// +----------------------------------------------------------------------+
// | iob_iob2wb_bridge: registered IOb slave to Wishbone classic master   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module iob_iob2wb_bridge
    import iob_wb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int READ_BYTES     = 4,
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                valid_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ready_o,
    output logic                err_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic                wb_ack_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_err_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int OFF_W = $clog2(SEL_W);

    state_t              state_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [SEL_W-1:0]    sel_q;
    logic                we_q;
    logic                cyc_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                ready_q;

    logic                w_we;
    logic [SEL_W-1:0]    w_rd_sel;
    logic                w_tc;

    assign w_we     = |wstrb_i;
    assign w_rd_sel = SEL_W'(rd_sel_mask(BYTE_OFF_W_MAX'(addr_i[OFF_W-1:0]), READ_BYTES));

    iob_wb_timeout_cnt #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .clr_i  (state_q != ST_BUS),
        .en_i   (state_q == ST_BUS),
        .tc_o   (w_tc)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            dat_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        adr_q   <= addr_i;
                        dat_q   <= wdata_i;
                        we_q    <= w_we;
                        sel_q   <= w_we ? wstrb_i : w_rd_sel;
                        cyc_q   <= 1'b1;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Bus error outranks ack, and both outrank the timeout.
                    if (wb_err_i || wb_ack_i || w_tc) begin
                        cyc_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_RESP;
                        if (wb_err_i || !wb_ack_i) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            err_q   <= 1'b0;
                            rdata_q <= we_q ? '0 : wb_dat_i;
                        end
                    end
                end
                ST_RESP: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    cyc_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata_o  = rdata_q;
    assign ready_o  = ready_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_dat_o = dat_q;

endmodule

`default_nettype wire

// File: tb/tb_iob_iob2wb_bridge.sv
// +----------------------------------------------------------------------+
// | tb_iob_iob2wb_bridge: randomized bench with a transaction-level model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_iob_iob2wb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
    localparam int NDUT = 3;

    // Slave response kinds
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          valid = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          ack = 1'b0;
    logic [DW-1:0] sdat = '0;
    logic          serr = 1'b0;

    logic [DW-1:0] rdata [NDUT];
    logic          ready [NDUT];
    logic          err   [NDUT];
    logic          busy  [NDUT];
    logic [AW-1:0] adr   [NDUT];
    logic [SW-1:0] sel   [NDUT];
    logic          we    [NDUT];
    logic          cyc   [NDUT];
    logic          stb   [NDUT];
    logic [DW-1:0] dat   [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Three copies differing only in READ_BYTES (4, 2, 1) share all stimulus.
    generate
        for (genvar i = 0; i < NDUT; i++) begin : g_dut
            iob_iob2wb_bridge #(
                .ADDR_W         (AW),
                .DATA_W         (DW),
                .READ_BYTES     (4 >> i),
                .TIMEOUT_W      (8),
                .TIMEOUT_CYCLES (TO)
            ) u_dut (
                .clk_i    (clk),
                .arst_i   (arst),
                .valid_i  (valid),
                .addr_i   (addr),
                .wdata_i  (wdata),
                .wstrb_i  (wstrb),
                .rdata_o  (rdata[i]),
                .ready_o  (ready[i]),
                .err_o    (err[i]),
                .busy_o   (busy[i]),
                .wb_adr_o (adr[i]),
                .wb_sel_o (sel[i]),
                .wb_we_o  (we[i]),
                .wb_cyc_o (cyc[i]),
                .wb_stb_o (stb[i]),
                .wb_dat_o (dat[i]),
                .wb_ack_i (ack),
                .wb_dat_i (sdat),
                .wb_err_i (serr)
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte lanes a request should select: write strobes, or a READ_BYTES-wide
    // window containing the addressed byte.
    function automatic logic [SW-1:0] exp_sel(input logic [AW-1:0] a, input logic [SW-1:0] ws,
                                              input int rb);
        int lane;
        int first;
        logic [SW-1:0] m;
        if (ws != '0) return ws;
        lane  = int'(a % 32'd4);
        first = (lane / rb) * rb;
        m = '0;
        for (int b = 0; b < rb; b++) m[first + b] = 1'b1;
        return m;
    endfunction

    // One complete IOb transaction. rc = BUS cycle (1-based) in which the slave
    // responds with `kind`; hold keeps valid_i high (with junk) while busy.
    task automatic txn(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                       input int rc, input int kind, input bit hold);
        logic [DW-1:0] slave_word;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        int            nbus;
        bit            timed_out;

        slave_word = $urandom;
        timed_out  = (kind == K_NONE) || (rc > TO);
        nbus       = timed_out ? TO : rc;
        if (timed_out || kind == K_ERR || kind == K_BOTH) begin
            exp_err = 1'b1;
            exp_rd  = '0;
        end else begin
            exp_err = 1'b0;
            exp_rd  = (ws != '0) ? '0 : slave_word;
        end

        check_eq("idle_busy", 32'(busy[0]), 32'd0);
        valid = 1'b1;
        addr  = a;
        wdata = wd;
        wstrb = ws;
        step();
        if (hold) begin
            addr  = $urandom;
            wdata = $urandom;
            wstrb = SW'($urandom);
        end else begin
            valid = 1'b0;
        end

        for (int k = 1; k <= nbus; k++) begin
            check_eq("bus_cyc", 32'(cyc[0]), 32'd1);
            check_eq("bus_stb", 32'(stb[0]), 32'd1);
            check_eq("bus_busy", 32'(busy[0]), 32'd1);
            check_eq("bus_ready", 32'(ready[0]), 32'd0);
            check_eq("bus_adr", adr[0], a);
            check_eq("bus_we", 32'(we[0]), 32'(ws != '0));
            check_eq("bus_dat", dat[0], wd);
            for (int i = 0; i < NDUT; i++)
                check_eq($sformatf("bus_sel_rb%0d", 4 >> i), 32'(sel[i]), 32'(exp_sel(a, ws, 4 >> i)));
            if (k == rc && kind != K_NONE) begin
                ack  = (kind == K_ACK) || (kind == K_BOTH);
                serr = (kind == K_ERR) || (kind == K_BOTH);
                sdat = slave_word;
            end else begin
                ack  = 1'b0;
                serr = 1'b0;
                sdat = $urandom;
            end
            step();
        end
        ack  = 1'b0;
        serr = 1'b0;

        check_eq("resp_ready", 32'(ready[0]), 32'd1);
        check_eq("resp_err", 32'(err[0]), 32'(exp_err));
        check_eq("resp_rdata", rdata[0], exp_rd);
        check_eq("resp_cyc", 32'(cyc[0]), 32'd0);
        check_eq("resp_stb", 32'(stb[0]), 32'd0);
        check_eq("resp_busy", 32'(busy[0]), 32'd1);
        step();
        valid = 1'b0;
        ack   = 1'($urandom);
        serr  = 1'($urandom);
        check_eq("post_ready", 32'(ready[0]), 32'd0);
        check_eq("post_busy", 32'(busy[0]), 32'd0);
        check_eq("post_cyc", 32'(cyc[0]), 32'd0);
        step();
        ack  = 1'b0;
        serr = 1'b0;
        check_eq("idle_ready", 32'(ready[0]), 32'd0);
        check_eq("idle_cyc", 32'(cyc[0]), 32'd0);
    endtask

    initial begin
        #2;
        check_eq("rst_ready", 32'(ready[0]), 32'd0);
        check_eq("rst_err", 32'(err[0]), 32'd0);
        check_eq("rst_rdata", rdata[0], 32'd0);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        check_eq("rst_cyc", 32'(cyc[0]), 32'd0);
        check_eq("rst_stb", 32'(stb[0]), 32'd0);
        check_eq("rst_we", 32'(we[0]), 32'd0);
        check_eq("rst_sel", 32'(sel[0]), 32'd0);
        check_eq("rst_adr", adr[0], 32'd0);
        check_eq("rst_dat", dat[0], 32'd0);
        step();
        arst = 1'b0;
        step();

        // Directed cases from the block's intended use
        txn(32'h10, 32'h0, 4'h0, 3, K_ACK, 1'b0);
        txn(32'h20, 32'h12345678, 4'h3, 1, K_ACK, 1'b0);
        txn(32'h6, 32'h0, 4'h0, 1, K_ACK, 1'b0);
        txn(32'h7, 32'h0, 4'h0, 2, K_ACK, 1'b0);
        txn(32'h40, 32'h0, 4'h0, 1, K_NONE, 1'b0);
        txn(32'h44, 32'hA5A5A5A5, 4'hF, 2, K_BOTH, 1'b0);
        txn(32'h48, 32'h0, 4'h0, TO, K_ACK, 1'b0);
        txn(32'h4C, 32'h0, 4'h0, 1, K_ERR, 1'b1);
        txn(32'h50, 32'h0, 4'h0, 2, K_ACK, 1'b1);

        // Reset while a cycle is outstanding
        valid = 1'b1;
        addr  = 32'h80;
        wstrb = '0;
        step();
        valid = 1'b0;
        step();
        check_eq("mid_cyc_before", 32'(cyc[0]), 32'd1);
        #1 arst = 1'b1;
        #1;
        check_eq("mid_rst_cyc", 32'(cyc[0]), 32'd0);
        check_eq("mid_rst_stb", 32'(stb[0]), 32'd0);
        check_eq("mid_rst_ready", 32'(ready[0]), 32'd0);
        check_eq("mid_rst_busy", 32'(busy[0]), 32'd0);
        step();
        arst = 1'b0;
        step();
        txn(32'h84, 32'h0, 4'h0, 2, K_ACK, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [SW-1:0] ws;
            ws = ($urandom % 2 == 0) ? '0 : SW'($urandom);
            txn($urandom, $urandom, ws, 1 + int'($urandom % (TO + 1)), int'($urandom % 4),
                1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
